// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding and the wait-counter width.
// No logic lives here.
package dmem_pkg;

  // Responder FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Wait counter width; covers LATENCY-1 for LATENCY up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data RAM: 2**ADDR_W words of DATA_W bits.
// Latency: write takes effect at the clock edge; the read path is combinational.
// Backpressure: none; the caller owns all sequencing.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] widx,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ridx,
  output logic [DATA_W-1:0] rd
);

  // Storage is deliberately not reset: contents survive a responder reset
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wd;
    end
  end

  // Asynchronous read port
  assign rd = mem[ridx];

endmodule

// File: rtl/data_mem_responder.sv
// Slow data-memory responder: performs one load/store per request after a programmable wait.
// Latency: stall is high for LATENCY+1 cycles, then one RESP cycle pulses done (and rvalid for loads).
// Backpressure: stall holds the pipeline while busy; inputs are ignored outside IDLE.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2    // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              done,
  output logic              stall,
  output logic              misalign,
  output logic              conflict
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              is_store_q;
  logic              mis_q;
  logic              conf_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem_rd;
  logic              req;
  logic              access_fire;
  logic              unused_addr_hi;

  assign req = MemRead | MemWrite;

  // The memory operation happens on the edge that leaves WAIT
  assign access_fire = (state == S_WAIT) && (cnt == '0);

  // Stall is combinational in IDLE so the requesting instruction is frozen on its first cycle
  assign stall = (state == S_WAIT) || ((state == S_IDLE) && req);

  // Upper address bits fall outside the memory and simply wrap
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // FSM, request capture, wait counter and registered completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      is_store_q <= 1'b0;
      mis_q      <= 1'b0;
      conf_q     <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      done       <= 1'b0;
      rvalid     <= 1'b0;
      misalign   <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      done     <= 1'b0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      conflict <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            // Write wins when both strobes are high
            is_store_q <= MemWrite;
            conf_q     <= MemRead & MemWrite;
            mis_q      <= (addr[1:0] != 2'b00);
            idx_q      <= addr[ADDR_W+1:2];
            wdata_q    <= wdata;
            cnt        <= CNT_W'(LATENCY - 1);
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state    <= S_RESP;
            done     <= 1'b1;
            rvalid   <= ~is_store_q;
            misalign <= mis_q;
            conflict <= conf_q;
          end
        end
        S_RESP: begin
          // Pipeline advances on this edge; never re-sample the held request
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Load data register: updated only by a completing load, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (access_fire && !is_store_q) begin
      rdata <= mem_rd;
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (access_fire & is_store_q),
    .widx (idx_q),
    .wd   (wdata_q),
    .ridx (idx_q),
    .rd   (mem_rd)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios plus randomized loads/stores,
// checked every cycle against a transaction-level model of the memory and its timing.
module tb_data_mem_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BUDGET = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, done, stall, misalign, conflict;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: memory contents, which words are known, and the in-flight access
  logic [31:0] mm [DEPTH];
  bit          known [DEPTH];
  bit          m_idle = 1'b1;
  int          m_age = 0;
  bit          m_load, m_mis, m_conf;
  int          m_idx = 0;
  logic [31:0] m_wd;
  logic [31:0] m_rdata = '0;
  bit          m_rdata_known = 1'b1;

  bit e_stall, e_done, e_rv, e_mis, e_conf;

  data_mem_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .done     (done),
    .stall    (stall),
    .misalign (misalign),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted request occupies the responder for LAT cycles after acceptance,
  // the memory operation lands at the end of that window, then one response cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle        = 1'b1;
      m_age         = 0;
      m_rdata       = '0;
      m_rdata_known = 1'b1;
    end else if (m_idle) begin
      if (MemRead || MemWrite) begin
        m_idle = 1'b0;
        m_age  = 0;
        m_load = !MemWrite;
        m_conf = MemRead && MemWrite;
        m_mis  = (addr % 4) != 0;
        m_idx  = int'((addr / 4) % DEPTH);
        m_wd   = wdata;
      end
    end else if (m_age == LAT) begin
      m_idle = 1'b1;
    end else begin
      m_age++;
      if (m_age == LAT) begin
        if (m_load) begin
          m_rdata       = mm[m_idx];
          m_rdata_known = known[m_idx];
        end else begin
          mm[m_idx]    = m_wd;
          known[m_idx] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (m_idle) begin
        e_stall = MemRead || MemWrite;
        e_done = 0; e_rv = 0; e_mis = 0; e_conf = 0;
      end else if (m_age < LAT) begin
        e_stall = 1;
        e_done = 0; e_rv = 0; e_mis = 0; e_conf = 0;
      end else begin
        e_stall = 0;
        e_done = 1; e_rv = m_load; e_mis = m_mis; e_conf = m_conf;
      end
      chk("cyc_stall", stall, e_stall);
      chk("cyc_done", done, e_done);
      chk("cyc_rvalid", rvalid, e_rv);
      chk("cyc_misalign", misalign, e_mis);
      chk("cyc_conflict", conflict, e_conf);
      if (m_rdata_known) chk("cyc_rdata", rdata, m_rdata);
    end
  end

  // Present one request (called just after a rising edge), wait for its done pulse,
  // then drop the strobes after the response edge as the pipeline would advance.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] g_rdata, output logic g_rv, output logic g_mis,
                        output logic g_conf, output int g_stalls, output int g_done_cyc);
    int n;
    bit seen;
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = d;
    g_stalls = 0; g_rdata = '0; g_rv = 0; g_mis = 0; g_conf = 0; g_done_cyc = -1;
    seen = 0;
    n = 0;
    while (!seen && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (stall) g_stalls++;
      if (done) begin
        seen       = 1;
        g_rdata    = rdata;
        g_rv       = rvalid;
        g_mis      = misalign;
        g_conf     = conflict;
        g_done_cyc = cyc;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  logic [31:0] g_rd;
  logic        g_rv, g_mis, g_conf;
  int          g_st, d1, d2;
  bit          seen;
  int          k, gap;
  bit          r, w;
  logic [31:0] a, d;

  initial begin
    // Power-on reset
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_conflict", conflict, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Store then load back
    access(0, 1, 32'h10, 32'hDEADBEEF, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    chk("st10_stall_cycles", g_st, LAT + 1);
    chk("st10_rvalid", g_rv, 0);
    chk("st10_misalign", g_mis, 0);
    access(1, 0, 32'h10, 32'h0, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    chk("ld10_rdata", g_rd, 32'hDEADBEEF);
    chk("ld10_rvalid", g_rv, 1);

    // Back-to-back loads: two responses, one accepting cycle between them
    access(0, 1, 32'h04, 32'h04040404, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    access(0, 1, 32'h08, 32'h08080808, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    access(1, 0, 32'h04, 32'h0, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    chk("b2b_first_rdata", g_rd, 32'h04040404);
    access(1, 0, 32'h08, 32'h0, g_rd, g_rv, g_mis, g_conf, g_st, d2);
    chk("b2b_second_rdata", g_rd, 32'h08080808);
    chk("b2b_spacing", d2 - d1, LAT + 2);
    @(negedge clk);
    chk("b2b_no_reaccept_stall", stall, 0);
    chk("b2b_no_reaccept_done", done, 0);
    @(posedge clk);
    #1;

    // Misaligned load and address wrap
    access(1, 0, 32'h13, 32'h0, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    chk("mis_rdata", g_rd, 32'hDEADBEEF);
    chk("mis_flag", g_mis, 1);
    access(0, 1, 32'h400, 32'h11112222, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    access(1, 0, 32'h0, 32'h0, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    chk("wrap_rdata", g_rd, 32'h11112222);
    chk("wrap_misalign", g_mis, 0);

    // Reset during WAIT discards the pending store
    access(0, 1, 32'h20, 32'h0BADF00D, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    MemWrite = 1'b1;
    addr     = 32'h20;
    wdata    = 32'h12345678;
    @(posedge clk);
    #3;
    rst      = 1'b1;
    MemWrite = 1'b0;
    @(negedge clk);
    chk("midwait_rst_stall", stall, 0);
    chk("midwait_rst_rdata", rdata, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    access(1, 0, 32'h20, 32'h0, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    chk("midwait_load_rdata", g_rd, 32'h0BADF00D);

    // Both strobes high: treated as a store, conflict flagged
    access(1, 1, 32'h24, 32'hA5A5A5A5, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    chk("conf_flag", g_conf, 1);
    chk("conf_rvalid", g_rv, 0);
    access(1, 0, 32'h24, 32'h0, g_rd, g_rv, g_mis, g_conf, g_st, d1);
    chk("conf_load_rdata", g_rd, 32'hA5A5A5A5);
    chk("conf_load_flag", g_conf, 0);

    // Asynchronous reset in the middle of a response cycle
    MemRead = 1'b1;
    addr    = 32'h10;
    seen    = 0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("arst_done_seen", 32'(seen), 32'd1);
    chk("arst_pre_rdata", rdata, 32'hDEADBEEF);
    #2;
    rst     = 1'b1;
    MemRead = 1'b0;
    #1;
    chk("arst_done", done, 0);
    chk("arst_rvalid", rvalid, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_stall", stall, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 7);
      r = (k < 3) || (k == 7);
      w = (k >= 3);
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      d = $urandom;
      access(r, w, a, d, g_rd, g_rv, g_mis, g_conf, g_st, d1);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
